mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one Wallace8x8 unsigned 8x8 multiplier instance among NUM_REQ requesters, such as neuron weight×input lanes.
- Round-robin arbitration on a valid/ready request side.
- Two-stage registered pipeline around the combinational multiplier.
- Single response channel returns the 16-bit product tagged with the requester id; full throughput of 1 product/cycle.

Parameters:
- NUM_REQ, 4, number of requesters; legal 2..16.
- ID_W, 2, width of the requester id; must be ≥ clog2(NUM_REQ).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- clear  in  1  reset: synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high.
- req_a  in  8*NUM_REQ  multiplicand; requester k uses bits [8k+7:8k].
- req_b  in  8*NUM_REQ  multiplier; requester k uses bits [8k+7:8k].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester owning rsp_product.
- rsp_product  out  16  a*b, unsigned.

Behaviour:
- Handshakes:
  - Request k is accepted in a cycle where req_valid[k] && req_ready[k].
  - Requester holds req_valid, req_a and req_b stable until accepted.
  - Response is consumed when rsp_valid && rsp_ready.
  - rsp_valid, rsp_id and rsp_product hold stable while rsp_valid && !rsp_ready.
- Stage S1 (operand register): s1_valid, s1_a, s1_b, s1_id.
  - s1_a and s1_b drive the shared Wallace8x8 instance.
- Stage S2 (output register): rsp_valid, rsp_product, rsp_id; captures multiplier output and s1_id.
- Advance rules:
  - s2_adv = !rsp_valid || rsp_ready.
  - s1_adv = !s1_valid || s2_adv.
  - req_ready is non-zero only when s1_adv = 1; it is combinational from req_valid, the pointer and s1_adv.
- Latency: accept in cycle T → rsp_valid in cycle T+2 with no backpressure.
- Throughput: back-to-back accepts every cycle while rsp_ready = 1.
- Arbitration:
  - Round-robin pointer last_grant; search starts at last_grant+1 modulo NUM_REQ and grants the first asserted req_valid.
  - last_grant updates only on an accept.
  - A requester idle at its turn is skipped with no lost cycle.
  - Single active requester gets every cycle.
- Backpressure:
  - rsp_ready low with S1 and S2 both full → req_ready = 0; S1 holds.
  - rsp_ready low with S2 full and S1 empty → one more accept fills S1, then req_ready = 0.
  - No product is dropped or duplicated.
- Simultaneous events:
  - rsp handshake and new accept in the same cycle: S2 reloads from S1, S1 reloads from the new request.
  - A valid request arriving with S1 empty and S2 full/stalled is accepted.
- Reset (clear = 1 at posedge):
  - s1_valid = 0, rsp_valid = 0, rsp_product = 16'h0000, rsp_id = 0, last_grant = NUM_REQ-1 (requester 0 wins first).
  - req_ready = 0 during the clear cycle.
  - In-flight operations are discarded; clear mid-stall drops both stages.
- Arithmetic: unsigned only; operands 8'hFF × 8'hFF = 16'hFE01; no truncation.
- Out-of-range ids never appear on rsp_id.

Optional Feature:
- Macro: MULT_SHARE_STATS_EN.
- Defined:
  - Adds outputs stat_ops (32-bit) and stat_stall (32-bit).
  - stat_ops increments on each request accept.
  - stat_stall increments each cycle rsp_valid && !rsp_ready.
  - Both saturate at 32'hFFFFFFFF, reset to 0 on clear, and update in the same cycle as the counted event.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset → single request: clear high 2 cycles then low; requester 0 sends a=8'd13, b=8'd11 with rsp_ready = 1 → rsp_valid 2 cycles after accept, rsp_product = 16'd143, rsp_id = 0; all outputs 0 during clear.
- Round-robin:
  - All 4 requesters valid continuously with rsp_ready = 1, operands a = k+1, b = 8'd10 → grants 0,1,2,3,0,… one per cycle.
  - Responses arrive in grant order with products 10, 20, 30, 40.
- Corner products: requester 2 sends 8'hFF×8'hFF, then 8'h00×8'hA5, then 8'h80×8'h02 → 16'hFE01, 16'h0000, 16'h0100, each with rsp_id = 2.
- Backpressure:
  - rsp_ready = 0 for 5 cycles while requesters 1 and 3 are valid → exactly 2 accepts, then req_ready = 0; rsp held stable.
  - Release rsp_ready → both products delivered in order; accepts resume at 1/cycle.
- Mid-operation reset: clear asserted with both stages full → next cycle rsp_valid = 0; the first post-clear grant goes to the lowest valid requester, with no stale response emitted.
- Stats (MULT_SHARE_STATS_EN): 10 accepts plus 3 stall cycles → stat_ops = 10, stat_stall = 3; clear → both 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one combinational 8x8 unsigned
// Wallace-tree multiplier among NUM_REQ valid/ready requesters. The datapath
// is an operand register (S1) feeding the multiplier and an output register
// (S2) holding the tagged product. It sustains one product per cycle.
// Optional build macro MULT_SHARE_STATS_EN adds the saturating counters
// stat_ops (accepted requests) and stat_stall (response stall cycles).

// Unsigned 8x8 multiplier. The eight partial products are reduced by layers
// of 3:2 carry-save compressors, and one carry-propagate add finishes the sum.
// A 16-bit width is exact because 255*255 fits in 16 bits.
module wallace8x8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [15:0] pp [8];
  logic [31:0] l1a, l1b, l2a, l2b, l3, l4;

  // Shifted AND-row partial products
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      pp[k] = {8'h00, a_i & {8{b_i[k]}}} << k;
    end
  end

  // Reduction layers: 8 -> 6 -> 4 -> 3 -> 2 rows
  assign l1a = csa(pp[0], pp[1], pp[2]);
  assign l1b = csa(pp[3], pp[4], pp[5]);
  assign l2a = csa(l1a[15:0], l1a[31:16], l1b[15:0]);
  assign l2b = csa(l1b[31:16], pp[6], pp[7]);
  assign l3  = csa(l2a[15:0], l2a[31:16], l2b[15:0]);
  assign l4  = csa(l3[15:0], l3[31:16], l2b[31:16]);
  assign p_o = l4[15:0] + l4[31:16];

endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_product
`ifdef MULT_SHARE_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [7:0]      a_arr [NUM_REQ];
  logic [7:0]      b_arr [NUM_REQ];

  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            s1_valid_q, s1_valid_d;
  logic [7:0]      s1_a_q, s1_a_d;
  logic [7:0]      s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_product_q, rsp_product_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            s2_adv, s1_adv, accept, gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  int              cand;
  logic [15:0]     mult_p;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[8*g +: 8];
    assign b_arr[g] = req_b[8*g +: 8];
  end

  assign s2_adv = !rsp_valid_q || rsp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Round-robin search starting after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    req_ready = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && req_valid[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
    // No grant while clearing or while S1 cannot take a new operand pair
    if (gnt_found && s1_adv && !clear) req_ready[gnt_idx] = 1'b1;
  end

  assign accept = gnt_found && s1_adv && !clear;

  wallace8x8 u_mult (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (mult_p)
  );

  // Next-state for the pointer and both pipeline stages
  always_comb begin
    last_grant_d  = last_grant_q;
    s1_valid_d    = s1_valid_q;
    s1_a_d        = s1_a_q;
    s1_b_d        = s1_b_q;
    s1_id_d       = s1_id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    if (accept) last_grant_d = ID_W'(gnt_idx);
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d  = a_arr[gnt_idx];
        s1_b_d  = b_arr[gnt_idx];
        s1_id_d = ID_W'(gnt_idx);
      end
    end
    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_product_d = mult_p;
        rsp_id_d      = s1_id_q;
      end
    end
  end

  // Control state and visible response registers; clear flushes both stages
  always_ff @(posedge clock) begin
    if (clear) begin
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      s1_valid_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= 16'h0000;
      rsp_id_q      <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      s1_valid_q    <= s1_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  // S1 operand/tag data registers; qualified by s1_valid_q, so no reset needed
  always_ff @(posedge clock) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_id_q <= s1_id_d;
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_id      = rsp_id_q;

`ifdef MULT_SHARE_STATS_EN
  logic [31:0] stat_ops_q, stat_stall_q;

  // Saturating event counters
  always_ff @(posedge clock) begin
    if (clear) begin
      stat_ops_q   <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      if (accept) stat_ops_q <= sat_inc(stat_ops_q);
      if (rsp_valid_q && !rsp_ready) stat_stall_q <= sat_inc(stat_stall_q);
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter (NUM_REQ=4, ID_W=2).
// Accepted requests push expected {id, a*b} into a scoreboard queue.
// Responses pop the queue and are compared in order.
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] prod;
  } rsp_t;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic [7:0]        a_arr [NUM_REQ];
  logic [7:0]        b_arr [NUM_REQ];
  logic [31:0]       req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_product;
`ifdef MULT_SHARE_STATS_EN
  logic [31:0]       stat_ops, stat_stall;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t exp_q [$];
  rsp_t rsp_log [$];
  int   gnt_log [$];

  logic            prev_stall = 1'b0;
  logic            prev_clear = 1'b1;
  logic [ID_W-1:0] prev_id = '0;
  logic [15:0]     prev_prod = '0;
  rsp_t            e;
  int              idx;

  assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  always #5 clock = ~clock;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
`ifdef MULT_SHARE_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_stall  (stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor on the falling edge: scoreboard, hold-while-stalled, grant legality
  always @(negedge clock) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", {30'd0, rsp_id}, {28'd0, e.id});
        check("rsp_prod", {16'd0, rsp_product}, {16'd0, e.prod});
      end
      rsp_log.push_back({2'b00, rsp_id, rsp_product});
      check("rsp_id_range", {31'd0, (int'(rsp_id) < NUM_REQ)}, 32'd1);
    end
    if (prev_stall && !prev_clear) begin
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_id", {30'd0, rsp_id}, {30'd0, prev_id});
      check("hold_prod", {16'd0, rsp_product}, {16'd0, prev_prod});
    end
    prev_stall = rsp_valid && !rsp_ready;
    prev_clear = clear;
    prev_id    = rsp_id;
    prev_prod  = rsp_product;
    if (req_ready != '0) begin
      check("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
      check("ready_needs_valid", {28'd0, req_ready & ~req_valid}, 32'd0);
      idx = 0;
      for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) idx = k;
      e.id   = 4'(idx);
      e.prod = {8'h00, a_arr[idx]} * {8'h00, b_arr[idx]};
      exp_q.push_back(e);
      gnt_log.push_back(idx);
    end
    if (clear) exp_q.delete();
  end

  initial begin
    logic [7:0]  ca [3];
    logic [7:0]  cb [3];
    logic [15:0] cp [3];
    ca[0] = 8'hFF; cb[0] = 8'hFF; cp[0] = 16'hFE01;
    ca[1] = 8'h00; cb[1] = 8'hA5; cp[1] = 16'h0000;
    ca[2] = 8'h80; cb[2] = 8'h02; cp[2] = 16'h0100;
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = 8'h00;
      b_arr[k] = 8'h00;
    end

    // Reset then a single request from requester 0
    step();
    check("clr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("clr_rsp_prod", {16'd0, rsp_product}, 32'd0);
    check("clr_rsp_id", {30'd0, rsp_id}, 32'd0);
    req_valid = 4'hF;
    #1;
    check("clr_req_ready", {28'd0, req_ready}, 32'd0);
    step();
    clear = 1'b0;
    req_valid = 4'b0001;
    a_arr[0] = 8'd13;
    b_arr[0] = 8'd11;
    #1;
    check("first_grant", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = '0;
    check("lat_t1_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    check("lat_t2_valid", {31'd0, rsp_valid}, 32'd1);
    check("lat_t2_prod", {16'd0, rsp_product}, 32'd143);
    check("lat_t2_id", {30'd0, rsp_id}, 32'd0);
    step();

    // Round robin with all requesters valid
    clear = 1'b1;
    step();
    clear = 1'b0;
    gnt_log.delete();
    rsp_log.delete();
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = 8'(k + 1);
      b_arr[k] = 8'd10;
    end
    req_valid = 4'hF;
    repeat (8) step();
    req_valid = '0;
    repeat (3) step();
    check("rr_grants", gnt_log.size(), 32'd8);
    for (int i = 0; i < gnt_log.size(); i++)
      check($sformatf("rr_gnt%0d", i), gnt_log[i], i % 4);
    check("rr_rsps", rsp_log.size(), 32'd8);
    for (int i = 0; i < rsp_log.size(); i++) begin
      check($sformatf("rr_id%0d", i), {28'd0, rsp_log[i].id}, i % 4);
      check($sformatf("rr_prod%0d", i), {16'd0, rsp_log[i].prod}, 10 * (i % 4 + 1));
    end

    // Corner products from requester 2
    rsp_log.delete();
    for (int i = 0; i < 3; i++) begin
      a_arr[2] = ca[i];
      b_arr[2] = cb[i];
      req_valid = 4'b0100;
      #1;
      check($sformatf("corner_ready%0d", i), {28'd0, req_ready}, 32'h4);
      step();
    end
    req_valid = '0;
    repeat (3) step();
    check("corner_rsps", rsp_log.size(), 32'd3);
    for (int i = 0; i < rsp_log.size(); i++) begin
      check($sformatf("corner_id%0d", i), {28'd0, rsp_log[i].id}, 32'd2);
      check($sformatf("corner_prod%0d", i), {16'd0, rsp_log[i].prod}, {16'd0, cp[i]});
    end

    // Backpressure with requesters 1 and 3
    rsp_log.delete();
    gnt_log.delete();
    rsp_ready = 1'b0;
    a_arr[1] = 8'h21; b_arr[1] = 8'h07;
    a_arr[3] = 8'hC3; b_arr[3] = 8'h5A;
    req_valid = 4'b1010;
    repeat (5) step();
    check("bp_accepts", gnt_log.size(), 32'd2);
    check("bp_req_ready", {28'd0, req_ready}, 32'd0);
    check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_rsp_id", {30'd0, rsp_id}, 32'd3);
    check("bp_rsp_prod", {16'd0, rsp_product}, 32'd17550);
    rsp_ready = 1'b1;
    repeat (4) step();
    req_valid = '0;
    repeat (3) step();
    check("bp_total_accepts", gnt_log.size(), 32'd6);
    for (int i = 0; i < gnt_log.size(); i++)
      check($sformatf("bp_gnt%0d", i), gnt_log[i], (i % 2 == 0) ? 3 : 1);
    check("bp_rsps", rsp_log.size(), 32'd6);

    // Clear while both stages are full and stalled
    rsp_ready = 1'b0;
    a_arr[0] = 8'd9; b_arr[0] = 8'd9;
    req_valid = 4'b0001;
    repeat (3) step();
    check("mr_full_valid", {31'd0, rsp_valid}, 32'd1);
    clear = 1'b1;
    req_valid = 4'b1001;
    #1;
    check("mr_ready_clr", {28'd0, req_ready}, 32'd0);
    step();
    clear = 1'b0;
    rsp_log.delete();
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #1;
    check("mr_grant", {28'd0, req_ready}, 32'h1);
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    repeat (3) step();
    check("mr_rsps", rsp_log.size(), 32'd1);
    for (int i = 0; i < rsp_log.size(); i++) begin
      check("mr_rsp_id", {28'd0, rsp_log[i].id}, 32'd0);
      check("mr_rsp_prod", {16'd0, rsp_log[i].prod}, 32'd81);
    end

`ifdef MULT_SHARE_STATS_EN
    // Statistics: 10 accepts and 3 stall cycles
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("st_ops_rst", stat_ops, 32'd0);
    check("st_stall_rst", stat_stall, 32'd0);
    a_arr[0] = 8'd3; b_arr[0] = 8'd4;
    req_valid = 4'b0001;
    repeat (10) step();
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    repeat (3) step();
    check("st_ops", stat_ops, 32'd10);
    check("st_stall", stat_stall, 32'd3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("st_ops_clr", stat_ops, 32'd0);
    check("st_stall_clr", stat_stall, 32'd0);
`endif

    step();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
